matrix_inv_q2_14: RTL

MATRIX_INV_Q2_14 -- requirements
Module: matrix_inv_q2_14

---
 rtl/matrix_q2_14_pkg.sv | 36 +++
 rtl/restoring_div_u.sv | 57 +++++
 rtl/matrix_inv_q2_14.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/matrix_q2_14_pkg.sv
// Shared widths, thresholds and FSM encoding for the Q2.14 2x2 matrix inverter.
// Includes the output saturation helper.
package matrix_q2_14_pkg;

  localparam int DATA_W      = 16;
  localparam int FRAC_W      = 14;
  localparam int DIV_ITER    = 32;
  localparam int SING_THRESH = 4096;

  localparam int DET_W   = 33;
  localparam int RECIP_W = 32;
  localparam int DVD_W   = 45;
  localparam int ADJ_W   = DATA_W + 1;
  localparam int PROD_W  = ADJ_W + RECIP_W + 1;

  // 2^44: a Q4.28 determinant times this reciprocal gives 2^16 scaling.
  localparam logic [DVD_W-1:0] RECIP_NUM = {1'b1, {(DVD_W-1){1'b0}}};

  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(32767);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-32768);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DET  = 3'd1,
    DIV  = 3'd2,
    MUL  = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [PROD_W-1:0] v);
    if (v > SAT_MAX)      return DATA_W'(32767);
    else if (v < SAT_MIN) return DATA_W'(-32768);
    else                  return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/restoring_div_u.sv
// Unsigned restoring divider, one quotient bit per clock, DIV_ITER bits total.
// divisor must be held stable for the whole run; it is not latched.
module restoring_div_u
  import matrix_q2_14_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DVD_W-1:0]   dividend,
  input  logic [RECIP_W-1:0] divisor,
  output logic [RECIP_W-1:0] quotient,
  output logic               done
);

  logic [RECIP_W-1:0]       r_rem;
  logic [RECIP_W-1:0]       r_q;
  logic [DVD_W-RECIP_W-1:0] r_hi;
  logic [5:0]               r_cnt;
  logic                     r_run;

  logic [RECIP_W:0]   w_trial;
  logic [RECIP_W:0]   w_diff;
  logic               w_ge;
  logic               w_ovf;

  assign w_trial = {r_rem, r_q[RECIP_W-1]};
  assign w_diff  = w_trial - {1'b0, divisor};
  assign w_ge    = w_trial >= {1'b0, divisor};
  // A quotient that needs more than RECIP_W bits clamps to all ones.
  assign w_ovf   = RECIP_W'(r_hi) >= divisor;

  // done marks the cycle of the final iteration; quotient is valid from the next cycle.
  assign done     = r_run && (r_cnt == 6'd1);
  assign quotient = w_ovf ? {RECIP_W{1'b1}} : r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_q   <= '0;
      r_hi  <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start) begin
      r_rem <= RECIP_W'(dividend[DVD_W-1:RECIP_W]);
      r_hi  <= dividend[DVD_W-1:RECIP_W];
      r_q   <= dividend[RECIP_W-1:0];
      r_cnt <= 6'(DIV_ITER);
      r_run <= 1'b1;
    end else if (r_run) begin
      r_rem <= w_ge ? w_diff[RECIP_W-1:0] : w_trial[RECIP_W-1:0];
      r_q   <= {r_q[RECIP_W-2:0], w_ge};
      r_cnt <= r_cnt - 6'd1;
      if (r_cnt == 6'd1) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/matrix_inv_q2_14.sv
// 2x2 Q2.14 matrix inverse: determinant, serial reciprocal, then four adjugate multiplies.
// Results and the singular flag change only when the DONE state is entered.
module matrix_inv_q2_14
  import matrix_q2_14_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] A00,
  input  logic signed [DATA_W-1:0] A01,
  input  logic signed [DATA_W-1:0] A10,
  input  logic signed [DATA_W-1:0] A11,
  output logic                     busy,
  output logic                     done,
  output logic                     singular,
  output logic signed [DATA_W-1:0] C00,
  output logic signed [DATA_W-1:0] C01,
  output logic signed [DATA_W-1:0] C10,
  output logic signed [DATA_W-1:0] C11,
  output logic [2:0]               dbg_state
);

  state_e r_state;
  logic signed [DATA_W-1:0] r_a00, r_a01, r_a10, r_a11;
  logic signed [DATA_W-1:0] r_stg00, r_stg01, r_stg10;
  logic                     r_det_neg;
  logic [RECIP_W-1:0]       r_det_mag;
  logic [1:0]               r_idx;

  logic signed [2*DATA_W-1:0] w_p0, w_p1;
  logic signed [DET_W-1:0]    w_det;
  logic signed [DET_W-1:0]    w_det_negv;
  logic [RECIP_W-1:0]         w_det_mag;
  logic                       w_sing;
  logic                       w_div_start;
  logic                       w_div_done;
  logic [RECIP_W-1:0]         w_recip;
  logic signed [ADJ_W-1:0]    w_adj;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [PROD_W-1:0]   w_prod_s;
  logic signed [PROD_W-1:0]   w_shift;
  logic signed [DATA_W-1:0]   w_elem;

  assign w_p0       = r_a00 * r_a11;
  assign w_p1       = r_a01 * r_a10;
  assign w_det      = {w_p0[2*DATA_W-1], w_p0} - {w_p1[2*DATA_W-1], w_p1};
  assign w_det_negv = -w_det;
  assign w_det_mag  = w_det[DET_W-1] ? w_det_negv[RECIP_W-1:0] : w_det[RECIP_W-1:0];
  assign w_sing     = w_det_mag < RECIP_W'(SING_THRESH);

  assign w_div_start = (r_state == DET) && !w_sing;

  restoring_div_u u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_div_start),
    .dividend (RECIP_NUM),
    .divisor  (r_det_mag),
    .quotient (w_recip),
    .done     (w_div_done)
  );

  // 17-bit adjugate term so that negating -32768 stays exact.
  always_comb begin
    w_adj = '0;
    case (r_idx)
      2'd0: w_adj = {r_a11[DATA_W-1], r_a11};
      2'd1: w_adj = -{r_a01[DATA_W-1], r_a01};
      2'd2: w_adj = -{r_a10[DATA_W-1], r_a10};
      2'd3: w_adj = {r_a00[DATA_W-1], r_a00};
      default: w_adj = '0;
    endcase
  end

  assign w_prod   = w_adj * $signed({1'b0, w_recip});
  assign w_prod_s = r_det_neg ? -w_prod : w_prod;
  assign w_shift  = w_prod_s >>> 16;
  assign w_elem   = sat16(w_shift);

  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a00     <= '0;
      r_a01     <= '0;
      r_a10     <= '0;
      r_a11     <= '0;
      r_stg00   <= '0;
      r_stg01   <= '0;
      r_stg10   <= '0;
      r_det_neg <= 1'b0;
      r_det_mag <= '0;
      r_idx     <= '0;
      done      <= 1'b0;
      singular  <= 1'b0;
      C00       <= '0;
      C01       <= '0;
      C10       <= '0;
      C11       <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a00   <= A00;
            r_a01   <= A01;
            r_a10   <= A10;
            r_a11   <= A11;
            r_state <= DET;
          end
        end
        DET: begin
          r_det_neg <= w_det[DET_W-1];
          r_det_mag <= w_det_mag;
          if (w_sing) begin
            C00      <= '0;
            C01      <= '0;
            C10      <= '0;
            C11      <= '0;
            singular <= 1'b1;
            done     <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_state <= DIV;
          end
        end
        DIV: begin
          if (w_div_done) begin
            r_idx   <= 2'd0;
            r_state <= MUL;
          end
        end
        MUL: begin
          r_idx <= r_idx + 2'd1;
          case (r_idx)
            2'd0: r_stg00 <= w_elem;
            2'd1: r_stg01 <= w_elem;
            2'd2: r_stg10 <= w_elem;
            default: begin
              C00      <= r_stg00;
              C01      <= r_stg01;
              C10      <= r_stg10;
              C11      <= w_elem;
              singular <= 1'b0;
              done     <= 1'b1;
              r_state  <= DONE;
            end
          endcase
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
